tf_fifo_ctrl: RTL and testbench

Sequencer for the twiddle-factor FIFO in one radix FFT datapath. For each stage it fetches TF_NUM twiddle factors from the twiddle BRAM and pushes them into the FIFO. It then pops one factor per butterfly request and hands it to the butterfly unit. After STAGE_NUM stages it signals done and returns to idle.

---
 rtl/tf_fifo_ctrl.sv | 138 +++++++++++++
 tb/tb_tf_fifo_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tf_fifo_ctrl.sv
// tf_fifo_ctrl: fills the twiddle FIFO from BRAM per stage, then feeds the butterfly.
// Define TF_FIFO_CTRL_ERR_EN to add a sticky err output.
module tf_fifo_ctrl #(
  parameter int FLOAT_LEN    = 32,
  parameter int TF_NUM       = 8,
  parameter int TF_ADDR_LEN  = 3,
  parameter int STAGE_NUM    = 4,
  parameter int STAGE_LEN    = 2,
  parameter int ROM_ADDR_LEN = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    bfly_req,
  output logic                    rom_en,
  output logic [ROM_ADDR_LEN-1:0] rom_addr,
  input  logic [2*FLOAT_LEN-1:0]  rom_dout,
  output logic [2*FLOAT_LEN-1:0]  fifo_din,
  output logic                    fifo_wr_en,
  output logic                    fifo_rd_en,
  input  logic                    fifo_full,
  input  logic                    fifo_empty,
  input  logic [2*FLOAT_LEN-1:0]  fifo_dout,
  output logic [2*FLOAT_LEN-1:0]  tf_out,
  output logic                    tf_valid,
  output logic [STAGE_LEN-1:0]    stage,
  output logic                    busy,
  output logic                    done
`ifdef TF_FIFO_CTRL_ERR_EN
  ,
  output logic                    err
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_NEXT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [TF_ADDR_LEN:0] CNT_MAX =
    (TF_ADDR_LEN+1)'(TF_NUM);
  localparam logic [STAGE_LEN-1:0] LAST_STAGE =
    STAGE_LEN'(STAGE_NUM-1);

  logic [2:0]               state;
  logic [2:0]               nxt;
  logic [TF_ADDR_LEN:0]     iss_cnt;
  logic [TF_ADDR_LEN:0]     wr_cnt;
  logic [TF_ADDR_LEN:0]     rd_cnt;
  logic                     wr_q;
  logic                     rd_q;
  logic [2*FLOAT_LEN-1:0]   tf_hold;
  logic                     wr_last;
  logic                     fill_entry;

  assign rom_en = (state == S_FILL)
               && (iss_cnt < CNT_MAX)
               && !fifo_full;
  assign rom_addr = {stage, iss_cnt[TF_ADDR_LEN-1:0]};

  assign fifo_wr_en = wr_q;
  assign fifo_din   = wr_q ? rom_dout : '0;

  assign fifo_rd_en = (state == S_DRAIN)
                   && bfly_req
                   && !fifo_empty
                   && (rd_cnt < CNT_MAX);

  // fifo_dout is only valid in the cycle after a pop
  assign tf_valid = rd_q;
  assign tf_out   = rd_q ? fifo_dout : tf_hold;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  assign wr_last    = wr_q && (wr_cnt == CNT_MAX - 1'b1);
  assign fill_entry = (state != S_FILL) && (nxt == S_FILL);

  always_comb begin
    nxt = state;
    unique case (1'b1)
      (state == S_IDLE):  if (start) nxt = S_FILL;
      (state == S_FILL):  if (wr_last) nxt = S_DRAIN;
      (state == S_DRAIN): if (rd_cnt == CNT_MAX) nxt = S_NEXT;
      (state == S_NEXT):
        nxt = (stage == LAST_STAGE) ? S_DONE : S_FILL;
      (state == S_DONE):  nxt = S_IDLE;
      default:            nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      iss_cnt <= '0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      tf_hold <= '0;
      stage   <= '0;
    end else begin
      state <= nxt;
      wr_q  <= rom_en;
      rd_q  <= fifo_rd_en;
      if (rd_q) tf_hold <= fifo_dout;
      if (fill_entry) begin
        iss_cnt <= '0;
        wr_cnt  <= '0;
        rd_cnt  <= '0;
      end else begin
        if (rom_en)     iss_cnt <= iss_cnt + 1'b1;
        if (wr_q)       wr_cnt  <= wr_cnt + 1'b1;
        if (fifo_rd_en) rd_cnt  <= rd_cnt + 1'b1;
      end
      if (state == S_IDLE && start)
        stage <= '0;
      else if (state == S_NEXT && stage != LAST_STAGE)
        stage <= stage + 1'b1;
    end
  end

`ifdef TF_FIFO_CTRL_ERR_EN
  logic err_hit;

  // an overfull write is still issued; it is only flagged
  assign err_hit = ((state == S_DRAIN) && bfly_req
                    && fifo_empty && (rd_cnt < CNT_MAX))
                || (wr_q && fifo_full);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         err <= 1'b0;
    else if (err_hit) err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_tf_fifo_ctrl.sv
// tb_tf_fifo_ctrl: random stimulus against BRAM/FIFO models and a
// stream-order reference for tf_fifo_ctrl.
module tb_tf_fifo_ctrl;

  localparam int TFN = 8;
  localparam int TOT = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start, bfly_req;
  logic        rom_en;
  logic [4:0]  rom_addr;
  logic [63:0] rom_dout;
  logic [63:0] fifo_din;
  logic        fifo_wr_en, fifo_rd_en;
  logic        fifo_full, fifo_empty;
  logic [63:0] fifo_dout;
  logic [63:0] tf_out;
  logic        tf_valid;
  logic [1:0]  stage;
  logic        busy, done;
  logic        err;
  logic        force_full, force_empty;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tf_fifo_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .bfly_req(bfly_req),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en),
    .fifo_rd_en(fifo_rd_en), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .tf_out(tf_out), .tf_valid(tf_valid), .stage(stage),
    .busy(busy), .done(done)
`ifdef TF_FIFO_CTRL_ERR_EN
    , .err(err)
`endif
  );

`ifndef TF_FIFO_CTRL_ERR_EN
  assign err = 1'b0;
`endif

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] word(input int a);
    logic [31:0] h;
    h = 32'(a);
    return {h, h};
  endfunction

  // sampled handshake values, consumed by the models at posedge
  logic        s_en, s_wr, s_rd;
  logic [4:0]  s_addr;
  logic [63:0] s_din;
  int          fcnt = 0;
  logic [63:0] fq[$];

  assign fifo_full  = force_full  | (fcnt == TFN);
  assign fifo_empty = force_empty | (fcnt == 0);

  always @(posedge clk) begin
    if (!rst) begin
      fq.delete();
      fcnt      <= 0;
      rom_dout  <= {$urandom, $urandom};
      fifo_dout <= {$urandom, $urandom};
    end else begin
      if (s_en) rom_dout <= word(int'(s_addr));
      if (s_wr) fq.push_back(s_din);
      if (s_rd && fq.size() > 0) fifo_dout <= fq.pop_front();
      fcnt <= fq.size();
    end
  end

  // stream-level reference state
  int exp_addr, exp_wr, exp_tf;
  logic [63:0] last_tf;
  logic p_en, p_rd, exp_err;
  int m_wr, m_rd;
  int done_cnt, en_cnt, en_rise, rd_rise;

  always begin
    @(negedge clk);
    #4;
    if (!rst) begin
      s_en = 0; s_wr = 0; s_rd = 0;
      s_addr = '0; s_din = '0;
      exp_addr = 0; exp_wr = 0; exp_tf = 0;
      last_tf = '0; p_en = 0; p_rd = 0;
      exp_err = 0; m_wr = 0; m_rd = 0;
    end else begin
      s_en = rom_en; s_addr = rom_addr;
      s_wr = fifo_wr_en; s_din = fifo_din;
      s_rd = fifo_rd_en;
      chk("wr_after_en", 64'(fifo_wr_en), 64'(p_en));
      chk("valid_after_rd", 64'(tf_valid), 64'(p_rd));
      chk("wr_rd_excl", 64'(fifo_wr_en & fifo_rd_en), 64'(0));
      if (fifo_full) chk("en_while_full", 64'(rom_en), 64'(0));
      if (fifo_rd_en) begin
        chk("rd_req", 64'(bfly_req), 64'(1));
        chk("rd_nonempty", 64'(fifo_empty), 64'(0));
      end
      if (rom_en) begin
        chk("rom_addr", 64'(rom_addr), 64'(exp_addr % TOT));
        chk("stage", 64'(stage), 64'((exp_addr % TOT) / TFN));
        exp_addr++; en_cnt++;
        if (!p_en) en_rise++;
        if (m_wr == TFN) begin m_wr = 0; m_rd = 0; end
      end
      if (fifo_wr_en) begin
        chk("fifo_din", fifo_din, word(exp_wr % TOT));
        exp_wr++;
      end
      if (tf_valid) begin
        chk("tf_out", tf_out, word(exp_tf % TOT));
        last_tf = word(exp_tf % TOT);
        exp_tf++;
      end else begin
        chk("tf_hold", tf_out, last_tf);
      end
      if (fifo_rd_en && !p_rd) rd_rise++;
      if (done) done_cnt++;
`ifdef TF_FIFO_CTRL_ERR_EN
      chk("err", 64'(err), 64'(exp_err));
      if ((m_wr == TFN && m_rd < TFN && bfly_req && fifo_empty)
          || (fifo_wr_en && fifo_full))
        exp_err = 1;
`endif
      if (fifo_wr_en) m_wr++;
      if (fifo_rd_en) m_rd++;
      p_en = rom_en;
      p_rd = fifo_rd_en;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_rom_en"}, 64'(rom_en), 64'(0));
    chk({tag, "_rom_addr"}, 64'(rom_addr), 64'(0));
    chk({tag, "_din"}, fifo_din, 64'(0));
    chk({tag, "_wr"}, 64'(fifo_wr_en), 64'(0));
    chk({tag, "_rd"}, 64'(fifo_rd_en), 64'(0));
    chk({tag, "_tf_out"}, tf_out, 64'(0));
    chk({tag, "_tf_valid"}, 64'(tf_valid), 64'(0));
    chk({tag, "_stage"}, 64'(stage), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_err"}, 64'(err), 64'(0));
  endtask

  int tf0;

  task automatic start_run();
    @(negedge clk);
    done_cnt = 0; en_cnt = 0; en_rise = 0; rd_rise = 0;
    tf0 = exp_tf;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic finish_run(input int rp, input int fp,
                            input bit poke, input bit bursts);
    int cyc = 0;
    while (done_cnt == 0 && cyc < 2000) begin
      bfly_req   = ($urandom_range(99) < rp);
      force_full = ($urandom_range(99) < fp);
      start      = poke && ($urandom_range(9) == 0);
      @(negedge clk);
      cyc++;
    end
    start = 0; bfly_req = 0; force_full = 0;
    chk("run_timeout", 64'(cyc < 2000), 64'(1));
    repeat (3) @(negedge clk);
    chk("done_pulses", 64'(done_cnt), 64'(1));
    chk("busy_after", 64'(busy), 64'(0));
    chk("tf_count", 64'(exp_tf - tf0), 64'(TOT));
    chk("en_count", 64'(en_cnt), 64'(TOT));
    if (bursts) begin
      chk("en_bursts", 64'(en_rise), 64'(4));
      chk("rd_bursts", 64'(rd_rise), 64'(4));
    end
  endtask

  initial begin
    bit found;
    start = 0; bfly_req = 0;
    force_full = 0; force_empty = 0;
    rst = 0;
    repeat (6) begin
      @(negedge clk);
      start = 1'($urandom); bfly_req = 1'($urandom);
      force_full = 1'($urandom); force_empty = 1'($urandom);
      #2 check_zero("in_rst");
    end
    @(negedge clk);
    start = 0; bfly_req = 0; force_full = 0; force_empty = 0;
    #1 rst = 1;
    @(negedge clk);
    #1 check_zero("post_rst");

    // continuous requests, stray start pulses mid-run
    start_run();
    finish_run(100, 0, 1, 1);

    // three-cycle full stall early in FILL
    start_run();
    bfly_req = 1;
    repeat (3) @(negedge clk);
    force_full = 1;
    repeat (3) begin
      #2 chk("stall_en", 64'(rom_en), 64'(0));
      @(negedge clk);
    end
    force_full = 0;
    #2 chk("resume_en", 64'(rom_en), 64'(1));
    finish_run(100, 0, 0, 0);

    repeat (4) begin
      start_run();
      finish_run(50, 20, 1, 0);
    end

    // asynchronous reset in stage 2 drain
    start_run();
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      bfly_req = 1;
      @(negedge clk);
      found = tf_valid && (stage == 2'd2);
    end
    chk("reach_s2", 64'(found), 64'(1));
    #2 rst = 0;
    #1 check_zero("mid_rst");
    bfly_req = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    start_run();
    finish_run(100, 0, 0, 1);

`ifdef TF_FIFO_CTRL_ERR_EN
    start_run();
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      bfly_req = 1;
      @(negedge clk);
      found = fifo_rd_en;
    end
    chk("reach_drain", 64'(found), 64'(1));
    force_empty = 1;
    @(negedge clk);
    #1 chk("err_set", 64'(err), 64'(1));
    force_empty = 0;
    finish_run(100, 0, 0, 0);
    chk("err_sticky", 64'(err), 64'(1));
    #2 rst = 0;
    #1 chk("err_clr", 64'(err), 64'(0));
    @(negedge clk);
    rst = 1;
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
